// File: rtl/macro_test_harness.sv
// macro_test_harness
//   Hosts up to NUM_CH hard macros behind a byte-wide command/response
//   interface. It drives each macro's inputs, captures its outputs, and
//   computes sweep signatures, so silicon can be characterised with a plain
//   byte-stream host.
//
// Parameters
//   NUM_CH  number of macro channels (1..31)
//   DW      macro input/output width per channel (1..8)
//   SETTLE  cycles between a drive update and the output sample (1..15)
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   cmd_valid/ready/data  command byte stream: opcode [7:5], arg [4:0]
//   rsp_valid/ready/data  response byte stream, held until rsp_ready
//   mac_in                registered drive; channel c is [c*DW +: DW]
//   mac_out               macro outputs, sampled SETTLE cycles after a drive
//   mac_en                one-hot enable of the selected channel
//
// Optional feature (compile-time macro MACRO_HARNESS_LOOPBACK_EN)
//   Adds a virtual loopback channel at index NUM_CH. Its output is an
//   internal register loaded from its own drive value one cycle later, and
//   mac_en is all zero while it is selected. The one-cycle delay means a
//   loopback sample only sees the new drive value when SETTLE >= 2.
//
// Sweep timing
//   The opcode is accepted in IDLE (one entry cycle). Each pattern then takes
//   SETTLE+1 cycles: SWP_DRV (1), SWP_WAIT (SETTLE-1, skipped if SETTLE==1),
//   SWP_SMP (1). The sample edge lands SETTLE cycles after the drive edge.
//   RESP is entered exactly 2^DW*(SETTLE+1) cycles after the accept edge.
//
// States
//   IDLE     | waiting for an opcode byte
//   ARG      | WRITE accepted, waiting for the data byte
//   WAIT     | CAPTURE settle countdown
//   SWP_DRV  | drive the current sweep pattern
//   SWP_WAIT | sweep settle countdown
//   SWP_SMP  | sample output, fold into signature, advance pattern
//   RESP     | response byte held until rsp_ready

module macro_test_harness #(
  parameter int NUM_CH = 4,
  parameter int DW     = 8,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  input  logic [7:0]           cmd_data,
  output logic                 cmd_ready,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_data,
  input  logic                 rsp_ready,
  output logic [NUM_CH*DW-1:0] mac_in,
  input  logic [NUM_CH*DW-1:0] mac_out,
  output logic [NUM_CH-1:0]    mac_en
);

  typedef enum logic [2:0] {
    IDLE, ARG, WAIT, SWP_DRV, SWP_WAIT, SWP_SMP, RESP
  } state_t;

  localparam logic [3:0]    CNT_CAP  = 4'(SETTLE - 1);
  localparam logic [3:0]    CNT_SWP  = 4'((SETTLE > 1) ? SETTLE - 2 : 0);
  localparam logic [DW-1:0] PAT_MAX  = '1;
  localparam logic [4:0]    NCH5     = 5'(NUM_CH);

  state_t                state_q, state_d;
  logic [4:0]            ch_q, ch_d;
  logic                  err_q, err_d;
  logic [DW-1:0]         sig_q, sig_d;
  logic [DW-1:0]         pat_q, pat_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [7:0]            rsp_data_q, rsp_data_d;
  logic                  stat_q, stat_d;
  logic [NUM_CH*DW-1:0]  mac_in_q, mac_in_d;

  logic [2:0]            op;
  logic [4:0]            arg;
  logic                  arg_ok;
  logic                  drv_en;
  logic [DW-1:0]         drv_val;
  logic [DW-1:0]         sel_out;
  logic [DW-1:0]         sig_rot;

  assign op  = cmd_data[7:5];
  assign arg = cmd_data[4:0];

`ifdef MACRO_HARNESS_LOOPBACK_EN
  logic [DW-1:0] lb_drv_q, lb_drv_d;
  logic [DW-1:0] lb_out_q;

  assign arg_ok   = (arg <= NCH5);
  assign lb_drv_d = (drv_en && ch_q == NCH5) ? drv_val : lb_drv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_drv_q <= '0;
      lb_out_q <= '0;
    end else begin
      lb_drv_q <= lb_drv_d;
      lb_out_q <= lb_drv_q;
    end
  end
`else
  assign arg_ok = (arg < NCH5);
`endif

  // Output of the selected channel; mac_out is only looked at after SETTLE.
  always_comb begin
    sel_out = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == 5'(c)) sel_out = mac_out[c*DW +: DW];
    end
`ifdef MACRO_HARNESS_LOOPBACK_EN
    if (ch_q == NCH5) sel_out = lb_out_q;
`endif
  end

  // Rotate-left by one, also correct for DW == 1.
  assign sig_rot = DW'({sig_q, sig_q} >> (DW - 1));

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    err_d      = err_q;
    sig_d      = sig_q;
    pat_d      = pat_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    stat_d     = stat_q;
    drv_en     = 1'b0;
    drv_val    = '0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (op)
            3'd0: ;
            3'd1: begin
              if (arg_ok) ch_d  = arg;
              else        err_d = 1'b1;
            end
            3'd2: state_d = ARG;
            3'd3: begin
              cnt_d   = CNT_CAP;
              state_d = WAIT;
            end
            3'd4: begin
              sig_d   = '0;
              pat_d   = '0;
              state_d = SWP_DRV;
            end
            3'd5: begin
              rsp_data_d = {err_q, 2'b00, ch_q};
              stat_d     = 1'b1;
              state_d    = RESP;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ARG: begin
        if (cmd_valid) begin
          drv_en  = 1'b1;
          drv_val = cmd_data[DW-1:0];
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d = 8'(sel_out);
          stat_d     = 1'b0;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SWP_DRV: begin
        drv_en  = 1'b1;
        drv_val = pat_q;
        cnt_d   = CNT_SWP;
        state_d = (SETTLE == 1) ? SWP_SMP : SWP_WAIT;
      end
      SWP_WAIT: begin
        if (cnt_q == 4'd0) state_d = SWP_SMP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      SWP_SMP: begin
        sig_d = sig_rot ^ sel_out;
        if (pat_q == PAT_MAX) begin
          rsp_data_d = 8'(sig_d);
          stat_d     = 1'b0;
          state_d    = RESP;
        end else begin
          pat_d   = pat_q + DW'(1);
          state_d = SWP_DRV;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          if (stat_q) err_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the selected channel is ever written; the rest hold.
  always_comb begin
    mac_in_d = mac_in_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (drv_en && ch_q == 5'(c)) mac_in_d[c*DW +: DW] = drv_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      err_q      <= 1'b0;
      sig_q      <= '0;
      pat_q      <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      stat_q     <= 1'b0;
      mac_in_q   <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      err_q      <= err_d;
      sig_q      <= sig_d;
      pat_q      <= pat_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      stat_q     <= stat_d;
      mac_in_q   <= mac_in_d;
    end
  end

  always_comb begin
    mac_en = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      mac_en[c] = (ch_q == 5'(c));
    end
  end

  assign cmd_ready = (state_q == IDLE) || (state_q == ARG);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign mac_in    = mac_in_q;

endmodule
